reg_shift_stack: RTL and testbench

Parametrised successor to the team's push-only register chain. A DEPTH-entry shift register bank with push and pop, an occupancy counter, full/empty status, and overflow handling. All entries remain visible in parallel. It sits between the operand-capture logic and the display/ALU path. The newest value is always at entry 0, and older values move toward entry DEPTH-1.

---
 rtl/reg_shift_stack.sv | 112 +++++++++++
 tb/tb_reg_shift_stack.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_shift_stack.sv
// Parallel-visible shift stack: newest entry at index 0, push/pop/replace-top, saturating occupancy.
// Optional sticky error flag enabled by defining REG_SHIFT_STACK_ERR_EN.
module reg_shift_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                push_i,
  input  logic                                pop_i,
  input  logic [WIDTH-1:0]                    data_i,
  output logic [DEPTH-1:0][WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH+1)-1:0]          count_o,
  output logic                                empty_o,
  output logic                                full_o,
  output logic                                drop_o,
  output logic                                err_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] entries_q, entries_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        drop_q, drop_d;
  logic                        empty, full;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == FULL_CNT) ? c : c + CW'(1);
  endfunction

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
    return (c == '0) ? c : c - CW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A push with pop on an empty stack degrades to a plain push; otherwise push+pop is replace-top.
  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    drop_d    = 1'b0;
    if (clear_i) begin
      entries_d = '0;
      count_d   = '0;
    end else if (push_i && (!pop_i || empty)) begin
      entries_d[0] = data_i;
      for (int i = 1; i < DEPTH; i++) begin
        entries_d[i] = entries_q[i-1];
      end
      count_d = sat_inc(count_q);
      drop_d  = full;
    end else if (push_i && pop_i) begin
      entries_d[0] = data_i;
    end else if (pop_i && !empty) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        entries_d[i] = entries_q[i+1];
      end
      entries_d[DEPTH-1] = '0;
      count_d = sat_dec(count_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      entries_q <= '0;
      count_q   <= '0;
      drop_q    <= 1'b0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
    end
  end

`ifdef REG_SHIFT_STACK_ERR_EN
  logic err_q, err_d;
  logic underflow;

  assign underflow = !clear_i && pop_i && empty;

  always_comb begin
    err_d = err_q;
    if (clear_i) begin
      err_d = 1'b0;
    end else if (drop_d || underflow) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign data_o  = entries_q;
  assign count_o = count_q;
  assign empty_o = empty;
  assign full_o  = full;
  assign drop_o  = drop_q;

endmodule

// File: tb/tb_reg_shift_stack.sv
// Scoreboard bench for reg_shift_stack (DEPTH=4, WIDTH=32); a queue-based model predicts each cycle.
module tb_reg_shift_stack;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef REG_SHIFT_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [CW-1:0]               count;
    logic                        empty;
    logic                        full;
    logic                        drop;
    logic                        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic clear_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic [DEPTH-1:0][WIDTH-1:0] data_o;
  logic [CW-1:0] count_o;
  logic empty_o, full_o, drop_o, err_o;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];
  bit   merr;
  exp_t sb[$];

  reg_shift_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .push_i(push_i), .pop_i(pop_i),
    .data_i(data_i), .data_o(data_o), .count_o(count_o), .empty_o(empty_o),
    .full_o(full_o), .drop_o(drop_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Update the model, queue the prediction, drive the inputs and advance one edge.
  task automatic apply(input bit clr, input bit psh, input bit pp, input logic [WIDTH-1:0] d);
    bit drop = 0, uf = 0;
    exp_t e;
    if (clr) begin
      mq.delete();
      merr = 0;
    end else if (psh && (!pp || mq.size() == 0)) begin
      uf = pp;
      if (mq.size() == DEPTH) begin
        void'(mq.pop_back());
        drop = 1;
      end
      mq.push_front(d);
    end else if (psh && pp) begin
      mq[0] = d;
    end else if (pp) begin
      if (mq.size() == 0) uf = 1;
      else void'(mq.pop_front());
    end
    if (ERR_EN && (drop || uf)) merr = 1;
    e.data = '0;
    foreach (mq[i]) e.data[i] = mq[i];
    e.count = CW'(mq.size());
    e.empty = (mq.size() == 0);
    e.full  = (mq.size() == DEPTH);
    e.drop  = drop;
    e.err   = merr;
    sb.push_back(e);
    clear_i = clr; push_i = psh; pop_i = pp; data_i = d;
    @(posedge clk);
    #1;
    clear_i = 0; push_i = 0; pop_i = 0; data_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 0;
    mq.delete();
    merr = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_o !== '0 || count_o !== '0 || empty_o !== 1'b1 || full_o !== 1'b0 ||
        drop_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%h count=%0d empty=%b full=%b drop=%b err=%b, want all zero/empty=1",
               data_o, count_o, empty_o, full_o, drop_o, err_o);
    end
    rst_i = 1;
  endtask

  task automatic test_push_fill();
    logic [WIDTH-1:0] vals [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
    exp_t e;
    foreach (vals[k]) begin
      apply(0, 1, 0, vals[k]);
      e = sb.pop_front();
      checks++;
      if ({data_o, count_o, empty_o, full_o, drop_o, err_o} !== e) begin
        errors++;
        $display("FAIL push_fill[%0d]: got data=%h cnt=%0d e/f/d/err=%b%b%b%b want data=%h cnt=%0d e/f/d/err=%b%b%b%b",
                 k, data_o, count_o, empty_o, full_o, drop_o, err_o, e.data, e.count, e.empty, e.full, e.drop, e.err);
      end
    end
    checks++;
    if (data_o !== {32'hA, 32'hB, 32'hC, 32'hD} || count_o !== 3'd4 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL push_fill_final: got data=%h cnt=%0d full=%b want D,C,B,A cnt=4 full=1",
               data_o, count_o, full_o);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) apply(0, 1, 0, 32'hE);
      else        apply(0, 0, 0, 32'h0);
      e = sb.pop_front();
      checks++;
      if ({data_o, count_o, empty_o, full_o, drop_o, err_o} !== e) begin
        errors++;
        $display("FAIL overflow[%0d]: got data=%h cnt=%0d e/f/d/err=%b%b%b%b want data=%h cnt=%0d e/f/d/err=%b%b%b%b",
                 k, data_o, count_o, empty_o, full_o, drop_o, err_o, e.data, e.count, e.empty, e.full, e.drop, e.err);
      end
    end
    checks++;
    if (data_o !== {32'hB, 32'hC, 32'hD, 32'hE} || err_o !== ERR_EN) begin
      errors++;
      $display("FAIL overflow_final: got data=%h err=%b want E,D,C,B err=%b", data_o, err_o, ERR_EN);
    end
  endtask

  task automatic test_pop_replace();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) apply(0, 0, 1, 32'h0);
      else       apply(0, 1, 1, 32'h7);
      e = sb.pop_front();
      checks++;
      if ({data_o, count_o, empty_o, full_o, drop_o, err_o} !== e) begin
        errors++;
        $display("FAIL pop_replace[%0d]: got data=%h cnt=%0d e/f/d/err=%b%b%b%b want data=%h cnt=%0d e/f/d/err=%b%b%b%b",
                 k, data_o, count_o, empty_o, full_o, drop_o, err_o, e.data, e.count, e.empty, e.full, e.drop, e.err);
      end
    end
    checks++;
    if (data_o !== {32'h0, 32'h0, 32'hB, 32'h7} || count_o !== 3'd2) begin
      errors++;
      $display("FAIL replace_final: got data=%h cnt=%0d want 7,B,0,0 cnt=2", data_o, count_o);
    end
  endtask

  task automatic test_underflow();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) apply(0, 0, 1, 32'h0);
      else       apply(0, 1, 1, 32'h5);
      e = sb.pop_front();
      checks++;
      if ({data_o, count_o, empty_o, full_o, drop_o, err_o} !== e) begin
        errors++;
        $display("FAIL underflow[%0d]: got data=%h cnt=%0d e/f/d/err=%b%b%b%b want data=%h cnt=%0d e/f/d/err=%b%b%b%b",
                 k, data_o, count_o, empty_o, full_o, drop_o, err_o, e.data, e.count, e.empty, e.full, e.drop, e.err);
      end
    end
    checks++;
    if (count_o !== 3'd1 || data_o[0] !== 32'h5 || err_o !== ERR_EN) begin
      errors++;
      $display("FAIL underflow_final: got cnt=%0d d0=%h err=%b want cnt=1 d0=5 err=%b",
               count_o, data_o[0], err_o, ERR_EN);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    apply(1, 0, 0, 32'h0);
    void'(sb.pop_front());
    for (int k = 0; k < 8; k++) begin
      if (k < 7) apply(0, 1, 0, $urandom);
      else       apply(0, 0, 0, 32'h0);
      e = sb.pop_front();
      checks++;
      if ({data_o, count_o, empty_o, full_o, drop_o, err_o} !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got data=%h cnt=%0d e/f/d/err=%b%b%b%b want data=%h cnt=%0d e/f/d/err=%b%b%b%b",
                 k, data_o, count_o, empty_o, full_o, drop_o, err_o, e.data, e.count, e.empty, e.full, e.drop, e.err);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) apply(0, 1, 0, 32'h30 + k);
      else       apply(1, 1, 0, 32'h9);
      e = sb.pop_front();
      checks++;
      if ({data_o, count_o, empty_o, full_o, drop_o, err_o} !== e) begin
        errors++;
        $display("FAIL clear[%0d]: got data=%h cnt=%0d e/f/d/err=%b%b%b%b want data=%h cnt=%0d e/f/d/err=%b%b%b%b",
                 k, data_o, count_o, empty_o, full_o, drop_o, err_o, e.data, e.count, e.empty, e.full, e.drop, e.err);
      end
    end
    checks++;
    if (data_o !== '0 || count_o !== '0 || empty_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_final: got data=%h cnt=%0d empty=%b err=%b want zeros", data_o, count_o, empty_o, err_o);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    apply(0, 1, 0, 32'h21);
    void'(sb.pop_front());
    apply(0, 0, 1, 32'h0);
    void'(sb.pop_front());
    apply(0, 1, 1, 32'h0);  // pop on empty: sets err when enabled
    void'(sb.pop_front());
    apply(0, 1, 0, 32'h22);
    e = sb.pop_front();
    checks++;
    if (count_o !== e.count || data_o !== e.data) begin
      errors++;
      $display("FAIL pre_async: got cnt=%0d data=%h want cnt=%0d data=%h", count_o, data_o, e.count, e.data);
    end
    #2 rst_i = 0;
    #1;
    checks++;
    if (data_o !== '0 || count_o !== '0 || empty_o !== 1'b1 || full_o !== 1'b0 ||
        drop_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data=%h count=%0d empty=%b full=%b drop=%b err=%b, want reset values",
               data_o, count_o, empty_o, full_o, drop_o, err_o);
    end
    #2 rst_i = 1;
    mq.delete();
    merr = 0;
    @(posedge clk);
    #1;
    apply(0, 1, 0, 32'h1);
    e = sb.pop_front();
    checks++;
    if ({data_o, count_o, empty_o, full_o, drop_o, err_o} !== e || count_o !== 3'd1 || data_o[0] !== 32'h1) begin
      errors++;
      $display("FAIL post_reset_push: got data=%h cnt=%0d want data=%h cnt=1", data_o, count_o, e.data);
    end
  endtask

  initial begin
    test_reset();
    test_push_fill();
    test_overflow();
    test_pop_replace();
    test_underflow();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
